tx_port_arbiter: RTL

Packet-atomic round-robin arbiter that merges four forwarder output FIFOs into one per-port TX FIFO, placed between the forwarder's `portN_din`/`portN_wr_en` staging FIFOs and the MAC TX path. It reads whole frames from one input at a time, so frames never interleave. It enforces a stall timeout on partially delivered frames and keeps frame and abort counters for the control plane.

---
 rtl/tx_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tx_port_arbiter.sv
// Packet-atomic round-robin arbiter: merges four FWFT input FIFOs into one TX FIFO,
// one whole frame at a time, with a mid-frame stall timeout and frame/abort counters.
module tx_port_arbiter #(
  parameter logic [15:0] StallTimeout = 16'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] in0_dout,
  input  logic [71:0] in1_dout,
  input  logic [71:0] in2_dout,
  input  logic [71:0] in3_dout,
  input  logic        in0_empty,
  input  logic        in1_empty,
  input  logic        in2_empty,
  input  logic        in3_empty,
  output logic        in0_rd_en,
  output logic        in1_rd_en,
  output logic        in2_rd_en,
  output logic        in3_rd_en,
  output logic [71:0] out_din,
  output logic        out_wr_en,
  input  logic        out_afull,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] abort_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT,
    DISCARD
  } state_t;

  state_t      state;
  logic [1:0]  rr;
  logic [15:0] stall_cnt;

  logic [3:0]  empty_vec;
  logic [71:0] dout_vec [4];
  logic        sel_empty;
  logic [71:0] sel_dout;
  logic        sel_last;
  logic        pop;
  logic [3:0]  rd_vec;
  logic [1:0]  pick;
  logic        found;

  assign empty_vec   = {in3_empty, in2_empty, in1_empty, in0_empty};
  assign dout_vec[0] = in0_dout;
  assign dout_vec[1] = in1_dout;
  assign dout_vec[2] = in2_dout;
  assign dout_vec[3] = in3_dout;

  assign sel_empty = empty_vec[grant];
  assign sel_dout  = dout_vec[grant];
  assign sel_last  = (sel_dout[71:64] != 8'hff);

  // Only the granted input is ever popped; TX backpressure is ignored while discarding.
  always_comb begin
    pop = 1'b0;
    if (sys_rst) begin
      case (state)
        XFER:    pop = !sel_empty && !out_afull;
        DISCARD: pop = !sel_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  assign rd_vec    = pop ? (4'b0001 << grant) : 4'b0000;
  assign in0_rd_en = rd_vec[0];
  assign in1_rd_en = rd_vec[1];
  assign in2_rd_en = rd_vec[2];
  assign in3_rd_en = rd_vec[3];

  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = rr + k[1:0];
      if (!found && !empty_vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state     <= IDLE;
      rr        <= 2'd0;
      grant     <= 2'd0;
      stall_cnt <= 16'd0;
      out_din   <= 72'h0;
      out_wr_en <= 1'b0;
      frame_cnt <= 16'd0;
      abort_cnt <= 16'd0;
    end else begin
      out_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= 16'd0;
          if (found) begin
            grant <= pick;
            state <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            out_din   <= sel_dout;
            out_wr_en <= 1'b1;
            stall_cnt <= 16'd0;
            if (sel_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              rr        <= grant + 2'd1;
              state     <= IDLE;
            end
          end else if (stall_cnt >= StallTimeout) begin
            state <= ABORT;
          end else if (sel_empty) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        // The almost-full margin guarantees room for the terminator word.
        ABORT: begin
          out_din   <= 72'h0;
          out_wr_en <= 1'b1;
          abort_cnt <= abort_cnt + 16'd1;
          stall_cnt <= 16'd0;
          state     <= DISCARD;
        end
        DISCARD: begin
          if (pop && sel_last) begin
            rr    <= grant + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
